// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game sequencer.
// Direction encodings are one-hot to match the button inputs.
package snake_pkg;

  localparam int SCORE_W = 6;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_PLAY = 3'd2,
    ST_STEP = 3'd3,
    ST_OVER = 3'd4
  } state_t;

  function automatic logic [3:0] opposite_dir(input logic [3:0] d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic logic is_one_hot(input logic [3:0] d);
    return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/snake_dir_queue.sv
// Direction command filter: press edge detect, reversal rejection and pending store.
// SNAKE_DIR_QUEUE_EN selects a 2-entry FIFO; otherwise a single overwrite register.
module snake_dir_queue
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       filt_en,
  input  logic       clear,
  input  logic       pop,
  input  logic [3:0] movement,
  output logic [3:0] cur_dir
);

  logic [3:0] move_prev_reg;
  logic [3:0] cur_dir_reg;
  logic [3:0] ref_dir;
  logic       press;
  logic       accept;
  logic       do_pop;

  assign press   = filt_en && (movement != 4'd0) && (movement != move_prev_reg);
  assign accept  = press && is_one_hot(movement) &&
                   (movement != ref_dir) && (movement != opposite_dir(ref_dir));
  assign cur_dir = cur_dir_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      move_prev_reg <= 4'd0;
    end else begin
      move_prev_reg <= movement;
    end
  end

`ifdef SNAKE_DIR_QUEUE_EN
  logic [3:0] q_reg [2];
  logic [1:0] count_reg;
  logic [1:0] count_after;
  logic       do_push;

  // A pop never changes the reference: the newest entry survives the pop or becomes cur_dir.
  always_comb begin
    ref_dir = cur_dir_reg;
    if (count_reg == 2'd2) begin
      ref_dir = q_reg[1];
    end else if (count_reg == 2'd1) begin
      ref_dir = q_reg[0];
    end
  end

  assign do_pop      = pop && (count_reg != 2'd0);
  assign count_after = count_reg - {1'b0, do_pop};
  assign do_push     = accept && (count_after != 2'd2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_dir_reg <= DIR_RIGHT;
      count_reg   <= 2'd0;
      q_reg[0]    <= DIR_RIGHT;
      q_reg[1]    <= DIR_RIGHT;
    end else if (clear) begin
      cur_dir_reg <= DIR_RIGHT;
      count_reg   <= 2'd0;
    end else begin
      if (do_pop) begin
        cur_dir_reg <= q_reg[0];
        q_reg[0]    <= q_reg[1];
      end
      if (do_push) begin
        q_reg[count_after[0]] <= movement;
      end
      count_reg <= count_after + {1'b0, do_push};
    end
  end
`else
  logic [3:0] pend_reg;
  logic       pend_valid_reg;

  assign do_pop  = pop && pend_valid_reg;
  assign ref_dir = do_pop ? pend_reg : cur_dir_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_dir_reg    <= DIR_RIGHT;
      pend_reg       <= DIR_RIGHT;
      pend_valid_reg <= 1'b0;
    end else if (clear) begin
      cur_dir_reg    <= DIR_RIGHT;
      pend_valid_reg <= 1'b0;
    end else begin
      if (do_pop) begin
        cur_dir_reg <= pend_reg;
      end
      if (accept) begin
        pend_reg       <= movement;
        pend_valid_reg <= 1'b1;
      end else if (do_pop) begin
        pend_valid_reg <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: phase FSM, score-dependent move tick, step handshake and score.
// Build with SNAKE_DIR_QUEUE_EN defined for a 2-deep direction queue.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_BASE = 128,
  parameter int TICK_STEP = 5,
  parameter int TICK_MIN  = 8,
  parameter int SCORE_MAX = 63
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         movement,
  input  logic               step_ack,
  input  logic               hit_wall,
  input  logic               hit_body,
  input  logic               ate_apple,
  output logic               init_req,
  output logic               step_req,
  output logic [3:0]         step_dir,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] score
);

  localparam logic signed [11:0] BASE_S = 12'(TICK_BASE);
  localparam logic signed [11:0] STEP_S = 12'(TICK_STEP);
  localparam logic signed [11:0] MIN_S  = 12'(TICK_MIN);

  state_t             state_reg, state_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic [8:0]         tick_reg, tick_next;
  logic               start_prev_reg;
  logic               start_edge;
  logic               pop;
  logic               filt_en;
  logic               clear;
  logic [SCORE_W-1:0] score_inc;
  logic signed [11:0] period_raw;
  logic [8:0]         period;
  logic [3:0]         cur_dir;

  assign start_edge = start && !start_prev_reg;
  assign score_inc  = (ate_apple && (score_reg != SCORE_W'(SCORE_MAX))) ?
                      score_reg + 1'b1 : score_reg;
  // Wide enough that the score product cannot wrap before the floor clamps it.
  assign period_raw = BASE_S - $signed({6'd0, score_inc}) * STEP_S;
  assign period     = (period_raw < MIN_S) ? 9'(TICK_MIN) : period_raw[8:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      score_reg      <= '0;
      tick_reg       <= 9'(TICK_BASE);
      start_prev_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      score_reg      <= score_next;
      tick_reg       <= tick_next;
      start_prev_reg <= start;
    end
  end

  always_comb begin
    state_next = state_reg;
    score_next = score_reg;
    tick_next  = tick_reg;
    init_req   = 1'b0;
    step_req   = 1'b0;
    pop        = 1'b0;
    filt_en    = 1'b0;
    clear      = 1'b0;
    case (state_reg)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          state_next = ST_INIT;
          score_next = '0;
        end
      end
      ST_INIT: begin
        init_req   = 1'b1;
        clear      = 1'b1;
        score_next = '0;
        tick_next  = 9'(TICK_BASE);
        state_next = ST_PLAY;
      end
      ST_PLAY: begin
        filt_en = 1'b1;
        if (tick_reg <= 9'd1) begin
          pop        = 1'b1;
          state_next = ST_STEP;
        end else begin
          tick_next = tick_reg - 9'd1;
        end
      end
      ST_STEP: begin
        step_req = 1'b1;
        filt_en  = 1'b1;
        if (step_ack) begin
          if (hit_wall || hit_body) begin
            state_next = ST_OVER;
            tick_next  = period_raw < MIN_S ? 9'(TICK_MIN) :
                         9'(BASE_S - $signed({6'd0, score_reg}) * STEP_S);
          end else begin
            score_next = score_inc;
            tick_next  = period;
            state_next = ST_PLAY;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  snake_dir_queue u_dir_queue (
    .clk      (clk),
    .reset    (reset),
    .filt_en  (filt_en),
    .clear    (clear),
    .pop      (pop),
    .movement (movement),
    .cur_dir  (cur_dir)
  );

  assign state    = state_reg;
  assign score    = score_reg;
  assign step_dir = cur_dir;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl: table of step transactions plus hand-written corner cases.
module tb_snake_game_ctrl;

  localparam int TIMEOUT = 300;

`ifdef SNAKE_DIR_QUEUE_EN
  localparam logic [3:0] D6 = 4'd4;
  localparam logic [3:0] D7 = 4'd4;
  localparam logic [3:0] D8 = 4'd2;
`else
  localparam logic [3:0] D6 = 4'd1;
  localparam logic [3:0] D7 = 4'd1;
  localparam logic [3:0] D8 = 4'd1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] movement = 4'd0;
  logic       step_ack = 1'b0;
  logic       hit_wall = 1'b0;
  logic       hit_body = 1'b0;
  logic       ate_apple = 1'b0;
  logic       init_req;
  logic       step_req;
  logic [3:0] step_dir;
  logic [2:0] state;
  logic [5:0] score;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] p0;
    logic [3:0] p1;
    logic       ate;
    int         period;
    logic [3:0] dir;
    logic [5:0] score;
  } vec_t;

  vec_t vecs [9];

  snake_game_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .movement  (movement),
    .step_ack  (step_ack),
    .hit_wall  (hit_wall),
    .hit_body  (hit_body),
    .ate_apple (ate_apple),
    .init_req  (init_req),
    .step_req  (step_req),
    .step_dir  (step_dir),
    .state     (state),
    .score     (score)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Counts PLAY cycles until step_req, injecting up to two button presses early on.
  task automatic wait_step(input logic [3:0] p0, input logic [3:0] p1, output int cnt);
    cnt = 0;
    while (!step_req && cnt < TIMEOUT) begin
      movement = (cnt == 2) ? p0 : (cnt == 4) ? p1 : 4'd0;
      tick();
      cnt++;
    end
    movement = 4'd0;
    if (!step_req) check("step_timeout", int'(step_req), 1);
  endtask

  task automatic ack(input logic ate, input logic wall, input logic body);
    step_ack  = 1'b1;
    ate_apple = ate;
    hit_wall  = wall;
    hit_body  = body;
    tick();
    step_ack  = 1'b0;
    ate_apple = 1'b0;
    hit_wall  = 1'b0;
    hit_body  = 1'b0;
  endtask

  initial begin
    int cnt;
    int guard;
    vecs[0] = '{4'd0, 4'd0, 1'b1, 128, 4'd8, 6'd1};
    vecs[1] = '{4'd0, 4'd0, 1'b1, 123, 4'd8, 6'd2};
    vecs[2] = '{4'd0, 4'd0, 1'b1, 118, 4'd8, 6'd3};
    vecs[3] = '{4'd4, 4'd0, 1'b0, 113, 4'd8, 6'd3};
    vecs[4] = '{4'd1, 4'd4, 1'b0, 113, 4'd1, 6'd3};
    vecs[5] = '{4'd0, 4'd0, 1'b0, 113, D6,   6'd3};
    vecs[6] = '{4'd3, 4'd0, 1'b0, 113, D7,   6'd3};
    vecs[7] = '{4'd2, 4'd0, 1'b0, 113, D8,   6'd3};
    vecs[8] = '{4'd8, 4'd0, 1'b1, 113, 4'd8, 6'd4};

    tick();
    tick();
    check("rst_state", int'(state), 0);
    check("rst_score", int'(score), 0);
    check("rst_init_req", int'(init_req), 0);
    check("rst_step_req", int'(step_req), 0);
    check("rst_step_dir", int'(step_dir), 8);
    reset = 1'b1;
    tick();
    tick();
    check("idle_hold", int'(state), 0);

    start = 1'b1;
    tick();
    check("init_state", int'(state), 1);
    check("init_pulse", int'(init_req), 1);
    start = 1'b0;
    tick();
    check("play_state", int'(state), 2);
    check("init_pulse_end", int'(init_req), 0);

    for (int i = 0; i < 9; i++) begin
      wait_step(vecs[i].p0, vecs[i].p1, cnt);
      check($sformatf("vec%0d_period", i), cnt, vecs[i].period);
      check($sformatf("vec%0d_dir", i), int'(step_dir), int'(vecs[i].dir));
      check($sformatf("vec%0d_state_step", i), int'(state), 3);
      ack(vecs[i].ate, 1'b0, 1'b0);
      check($sformatf("vec%0d_score", i), int'(score), int'(vecs[i].score));
      check($sformatf("vec%0d_state_play", i), int'(state), 2);
      check($sformatf("vec%0d_req_low", i), int'(step_req), 0);
      $display("vec %0d: period=%0d dir=%0d score=%0d", i, cnt, step_dir, score);
    end

    // Stray ack in PLAY must not score.
    ack(1'b1, 1'b0, 1'b0);
    check("stray_ack_score", int'(score), 4);
    check("stray_ack_state", int'(state), 2);

    guard = 0;
    while (score < 6'd24 && guard < 40) begin
      wait_step(4'd0, 4'd0, cnt);
      ack(1'b1, 1'b0, 1'b0);
      guard++;
    end
    check("reach_s24", int'(score), 24);
    wait_step(4'd0, 4'd0, cnt);
    check("period_s24", cnt, 8);
    ack(1'b1, 1'b0, 1'b0);
    wait_step(4'd0, 4'd0, cnt);
    check("period_clamp_s25", cnt, 8);
    ack(1'b1, 1'b0, 1'b0);
    $display("score 26 reached, period=%0d", cnt);

    guard = 0;
    while (score < 6'd63 && guard < 60) begin
      wait_step(4'd0, 4'd0, cnt);
      ack(1'b1, 1'b0, 1'b0);
      guard++;
    end
    check("reach_s63", int'(score), 63);
    wait_step(4'd0, 4'd0, cnt);
    ack(1'b1, 1'b0, 1'b0);
    check("score_sat", int'(score), 63);
    wait_step(4'd0, 4'd0, cnt);
    check("period_s63", cnt, 8);
    ack(1'b1, 1'b1, 1'b0);
    check("wall_over_state", int'(state), 4);
    check("wall_over_score", int'(score), 63);
    check("wall_over_req", int'(step_req), 0);
    $display("game over at score=%0d", score);
    movement = 4'd1;
    tick();
    movement = 4'd0;
    tick();
    check("over_hold", int'(state), 4);

    start = 1'b1;
    tick();
    check("restart_init", int'(state), 1);
    check("restart_score", int'(score), 0);
    check("restart_init_req", int'(init_req), 1);
    tick();
    wait_step(4'd0, 4'd0, cnt);
    check("restart_period", cnt, 128);
    check("restart_dir", int'(step_dir), 8);
    ack(1'b0, 1'b0, 1'b1);
    check("body_over_state", int'(state), 4);
    for (int i = 0; i < 3; i++) tick();
    check("start_held_no_retrig", int'(state), 4);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check("retrig_init", int'(state), 1);
    start = 1'b0;
    tick();
    wait_step(4'd0, 4'd0, cnt);
    ack(1'b1, 1'b0, 1'b0);
    check("pre_reset_score", int'(score), 1);
    wait_step(4'd0, 4'd0, cnt);
    check("pre_reset_req", int'(step_req), 1);

    reset = 1'b0;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_req", int'(step_req), 0);
    check("async_rst_score", int'(score), 0);
    check("async_rst_dir", int'(step_dir), 8);
    check("async_rst_init", int'(init_req), 0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("post_rst_idle", int'(state), 0);
    $display("reset mid-step done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
